// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared state type and arithmetic helpers for fir_tap_engine
package fir_pkg;

   typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_t;

   // Wide enough that NTAPS full-scale products can never overflow.
   function automatic int acc_width(input int dwidth, input int cwidth, input int ntaps);
      return dwidth + cwidth + $clog2(ntaps);
   endfunction

   function automatic logic signed [63:0] sat_fit(input logic signed [63:0] v, input int owidth);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] r;
      hi = (64'sd1 <<< (owidth - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      r  = v;
      if (v > hi)
         r = hi;
      else if (v < lo)
         r = lo;
      return r;
   endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// rtl/fir_mac_unit.sv - registered signed accumulator with synchronous clear and enable
module fir_mac_unit #(
   parameter int PWIDTH = 16,
   parameter int ACCW   = 18
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     en,
   input  logic signed [PWIDTH-1:0] product,
   output logic signed [ACCW-1:0]   sum
);

   logic signed [ACCW-1:0] acc;

   assign sum = acc + {{(ACCW-PWIDTH){product[PWIDTH-1]}}, product};

   always_ff @(posedge clk) begin
      if (rst || clear)
         acc <= '0;
      else if (en)
         acc <= sum;
   end

endmodule

// File: rtl/fir_tap_engine.sv
// rtl/fir_tap_engine.sv - sequential FIR stage: FIFO pop, NTAPS-cycle MAC, valid/ready result
// Define FIR_SAT_EN to saturate the result to the OWIDTH range instead of wrapping.
module fir_tap_engine
   import fir_pkg::*;
#(
   parameter int NTAPS  = 4,
   parameter int DWIDTH = 8,
   parameter int CWIDTH = 8,
   parameter int OWIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fifo_empty,
   input  logic                     fifo_write_en,
   input  logic [DWIDTH-1:0]        fifo_rdata,
   output logic                     fifo_read_en,
   input  logic                     coef_we,
   input  logic [$clog2(NTAPS)-1:0] coef_addr,
   input  logic [CWIDTH-1:0]        coef_wdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OWIDTH-1:0]        out_data,
   output logic                     busy
);

   localparam int IW   = $clog2(NTAPS);
   localparam int PW   = DWIDTH + CWIDTH;
   localparam int ACCW = acc_width(DWIDTH, CWIDTH, NTAPS);

   fir_state_t state, state_next;

   logic signed [DWIDTH-1:0] dl   [NTAPS];
   logic signed [CWIDTH-1:0] coef [NTAPS];
   logic [IW-1:0]            idx;
   logic                     pop_ok;
   logic                     last_tap;
   logic signed [DWIDTH-1:0] tap_sample;
   logic signed [CWIDTH-1:0] tap_coef;
   logic signed [PW-1:0]     product;
   logic signed [ACCW-1:0]   sum;
   logic signed [OWIDTH-1:0] result;

   // A pop during an upstream write would be ignored by the FIFO, so wait it out.
   assign pop_ok   = !fifo_empty && !fifo_write_en && !rst;
   assign last_tap = (idx == IW'(NTAPS - 1));

   assign tap_sample = dl[idx];
   assign tap_coef   = coef[idx];
   assign product    = $signed({{CWIDTH{tap_sample[DWIDTH-1]}}, tap_sample})
                     * $signed({{DWIDTH{tap_coef[CWIDTH-1]}}, tap_coef});

   fir_mac_unit #(
      .PWIDTH (PW),
      .ACCW   (ACCW)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clear   (fifo_read_en),
      .en      (state == MAC),
      .product (product),
      .sum     (sum)
   );

`ifdef FIR_SAT_EN
   logic signed [63:0] sum_sat;
   assign sum_sat = sat_fit(64'(sum), OWIDTH);
   assign result  = OWIDTH'(sum_sat);
`else
   assign result = OWIDTH'(sum);
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pop_ok) state_next = MAC;
         MAC:     if (last_tap) state_next = OUT;
         OUT:     if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      fifo_read_en = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b1;
      case (state)
         IDLE: begin
            busy         = 1'b0;
            fifo_read_en = pop_ok;
         end
         OUT:     out_valid = 1'b1;
         default: busy = 1'b1;
      endcase
   end

   // Coefficient writes land only while idle; the pop cycle counts as idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NTAPS; k++) begin
            dl[k]   <= '0;
            coef[k] <= '0;
         end
         idx      <= '0;
         out_data <= '0;
      end else begin
         if (coef_we && !busy)
            coef[coef_addr] <= coef_wdata;
         if (fifo_read_en) begin
            for (int k = NTAPS - 1; k > 0; k--)
               dl[k] <= dl[k-1];
            dl[0] <= fifo_rdata;
            idx   <= '0;
         end else if (state == MAC) begin
            idx <= idx + 1'b1;
            if (last_tap)
               out_data <= result;
         end
      end
   end

endmodule

// File: tb/tb_fir_tap_engine.sv
// tb/tb_fir_tap_engine.sv - randomized bench for fir_tap_engine against an arithmetic FIR model
module tb_fir_tap_engine;

   localparam int NTAPS  = 4;
   localparam int DWIDTH = 8;
   localparam int CWIDTH = 8;
   localparam int OWIDTH = 16;
   localparam int AW     = $clog2(NTAPS);

   logic              clk = 1'b0;
   logic              rst;
   logic              fifo_empty;
   logic              fifo_write_en;
   logic [DWIDTH-1:0] fifo_rdata;
   logic              fifo_read_en;
   logic              coef_we;
   logic [AW-1:0]     coef_addr;
   logic [CWIDTH-1:0] coef_wdata;
   logic              out_valid;
   logic              out_ready;
   logic [OWIDTH-1:0] out_data;
   logic              busy;

   fir_tap_engine #(
      .NTAPS  (NTAPS),
      .DWIDTH (DWIDTH),
      .CWIDTH (CWIDTH),
      .OWIDTH (OWIDTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_empty    (fifo_empty),
      .fifo_write_en (fifo_write_en),
      .fifo_rdata    (fifo_rdata),
      .fifo_read_en  (fifo_read_en),
      .coef_we       (coef_we),
      .coef_addr     (coef_addr),
      .coef_wdata    (coef_wdata),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int                checks = 0;
   int                errors = 0;
   int                cyc = 0;
   logic [DWIDTH-1:0] fq [$];
   logic [DWIDTH-1:0] wr_data;
   logic              pop_seen = 1'b0;
   int                m_dl [NTAPS];
   int                m_coef [NTAPS];
   bit                in_flight = 1'b0;
   int                pop_cyc = 0;
   int                pops = 0;
   logic [OWIDTH-1:0] exp_data = '0;
   logic [OWIDTH-1:0] got [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [OWIDTH-1:0] fit(input int s);
      int t;
      t = s;
`ifdef FIR_SAT_EN
      if (t > 32767)
         t = 32767;
      else if (t < -32768)
         t = -32768;
`endif
      return t[OWIDTH-1:0];
   endfunction

   function automatic int model_sum();
      int s;
      s = 0;
      for (int k = 0; k < NTAPS; k++)
         s += m_dl[k] * m_coef[k];
      return s;
   endfunction

   // Per-cycle compare against the model, then advance the model past the coming edge.
   always @(negedge clk) begin
      bit exp_pop;
      bit exp_valid;
      cyc++;
      exp_pop   = !rst && !in_flight && !fifo_empty && !fifo_write_en;
      exp_valid = in_flight && (cyc >= pop_cyc + NTAPS + 1);
      check("fifo_read_en", {31'd0, fifo_read_en}, {31'd0, exp_pop});
      check("busy", {31'd0, busy}, {31'd0, in_flight});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      if (exp_valid)
         check("out_data", {16'd0, out_data}, {16'd0, exp_data});
      pop_seen = fifo_read_en && !fifo_write_en && !fifo_empty;
      if (rst) begin
         in_flight = 1'b0;
         for (int k = 0; k < NTAPS; k++) begin
            m_dl[k]   = 0;
            m_coef[k] = 0;
         end
      end else begin
         if (coef_we && !in_flight)
            m_coef[coef_addr] = int'($signed(coef_wdata));
         if (exp_pop) begin
            for (int k = NTAPS - 1; k > 0; k--)
               m_dl[k] = m_dl[k-1];
            m_dl[0]   = int'($signed(fifo_rdata));
            exp_data  = fit(model_sum());
            in_flight = 1'b1;
            pop_cyc   = cyc;
            pops++;
         end else if (exp_valid && out_ready) begin
            got.push_back(out_data);
            in_flight = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      if (fifo_write_en)
         fq.push_back(wr_data);
      if (pop_seen)
         void'(fq.pop_front());
      #1;
      fifo_write_en = 1'b0;
      coef_we       = 1'b0;
      fifo_empty    = (fq.size() == 0);
      fifo_rdata    = (fq.size() != 0) ? fq[0] : '0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic push(input int v);
      fifo_write_en = 1'b1;
      wr_data       = DWIDTH'(v);
      step();
   endtask

   task automatic wcoef(input int a, input int v);
      coef_we    = 1'b1;
      coef_addr  = AW'(a);
      coef_wdata = CWIDTH'(v);
      step();
   endtask

   task automatic wait_for(input int target);
      int b;
      b = 0;
      while (got.size() < target && b < 400) begin
         step();
         b++;
      end
      if (got.size() < target) begin
         checks++;
         errors++;
         $display("FAIL wait_for: actual %0d results required %0d", got.size(), target);
      end
   endtask

   task automatic wait_sig(input string name, input bit want_busy);
      int b;
      b = 0;
      while (((want_busy ? busy : out_valid) !== 1'b1) && b < 50) begin
         step();
         b++;
      end
      if ((want_busy ? busy : out_valid) !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s: actual timeout required high", name);
      end
   endtask

   initial begin
      int base;
      int p0;
      int c_free;
      int b;
      rst = 1'b1; fifo_empty = 1'b1; fifo_write_en = 1'b0; fifo_rdata = '0; wr_data = '0;
      coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset out_data", {16'd0, out_data}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset fifo_read_en", {31'd0, fifo_read_en}, 32'd0);
      idle(20);

      // Impulse response reproduces the coefficient bank.
      for (int k = 0; k < NTAPS; k++) wcoef(k, k + 1);
      base = got.size();
      push(1); push(0); push(0); push(0);
      wait_for(base + 4);
      for (int k = 0; k < 4; k++) check("impulse", {16'd0, got[base+k]}, k + 1);

      // Reset mid-MAC wipes the delay line and coefficients.
      push(7);
      wait_sig("busy before reset", 1'b1);
      idle(2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      for (int k = 0; k < NTAPS; k++) wcoef(k, k + 1);
      base = got.size();
      push(0);
      wait_for(base + 1);
      check("delay line cleared", {16'd0, got[base]}, 32'd0);

      // Coefficient write while busy is dropped.
      base = got.size();
      push(0);
      wait_sig("busy for coef write", 1'b1);
      coef_we = 1'b1; coef_addr = '0; coef_wdata = 8'd9;
      step();
      wait_for(base + 1);
      push(1);
      wait_for(base + 2);
      check("coef write while busy", {16'd0, got[base+1]}, 32'd1);

      // Stall in OUT with three samples queued.
      out_ready = 1'b0;
      base = got.size();
      p0 = pops;
      push(2); push(3); push(5);
      wait_sig("valid before stall", 1'b0);
      idle(10);
      check("pops during stall", pops - p0, 32'd1);
      out_ready = 1'b1;
      wait_for(base + 3);
      check("stall out 0", {16'd0, got[base]}, 32'd4);
      check("stall out 1", {16'd0, got[base+1]}, 32'd10);
      check("stall out 2", {16'd0, got[base+2]}, 32'd21);

      // Held write strobe blocks the pop until the first write-free cycle.
      base = got.size();
      for (int k = 0; k < 5; k++) push(k + 1);
      c_free = cyc + 1;
      step();
      check("pop after write drops", pop_cyc, c_free);
      wait_for(base + 5);

      // Full-scale negative sum: wrap or saturate.
      for (int k = 0; k < NTAPS; k++) wcoef(k, 127);
      base = got.size();
      for (int k = 0; k < 4; k++) push(-128);
      wait_for(base + 4);
`ifdef FIR_SAT_EN
      check("saturated sum", {16'd0, got[base+3]}, 32'h8000);
`else
      check("wrapped sum", {16'd0, got[base+3]}, 32'h0200);
`endif

      // Randomized traffic, back-pressure, coefficient writes and rare resets.
      base = got.size();
      for (int i = 0; i < 3000; i++) begin
         out_ready = ($urandom_range(3) != 0);
         if (fq.size() < 6 && $urandom_range(3) == 0) begin
            fifo_write_en = 1'b1;
            wr_data       = DWIDTH'($urandom);
         end
         if ($urandom_range(7) == 0) begin
            coef_we    = 1'b1;
            coef_addr  = AW'($urandom);
            coef_wdata = CWIDTH'($urandom);
         end
         if ($urandom_range(999) == 0) rst = 1'b1;
         step();
         rst = 1'b0;
      end
      out_ready = 1'b1;
      b = 0;
      while ((fq.size() != 0 || in_flight) && b < 500) begin
         step();
         b++;
      end
      check("drained", {31'd0, (fq.size() == 0 && !in_flight)}, 32'd1);
      check("random results produced", {31'd0, (got.size() - base > 20)}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
